// File: rtl/color_palette_pkg.sv
// -----------------------------------------------------------------------------
// color_palette_pkg
//   Shared definitions for the programmable colour palette:
//     - state_e          : init-sequencer state (INIT fills the RAM, RUN serves)
//     - DEFAULT_PALETTE  : 16-entry default rainbow table, 8 bits per channel
//     - default_rgb()    : default entry for any palette index (index mod 16)
//     - adapt_ch8()      : resizes an 8-bit channel to an arbitrary width
//                          (truncate to the MSBs when narrowing, left-justify
//                          and repeat the MSBs into the low bits when widening)
// -----------------------------------------------------------------------------
package color_palette_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_ENTRIES = 16;

    // Entry 0 is the first value listed.
    localparam logic [0:DEF_ENTRIES-1][23:0] DEFAULT_PALETTE = {
        24'h000000, 24'hFF0000, 24'hFF8000, 24'hFFBF00,
        24'hFFFF00, 24'hBFFF00, 24'h80FF00, 24'h40FF00,
        24'h00FF00, 24'h00FF80, 24'h00FFBF, 24'h00FFFF,
        24'h0080FF, 24'h0000FF, 24'h4B0082, 24'h8F00FF
    };

    // Palettes deeper than 16 entries wrap around the default table.
    function automatic logic [23:0] default_rgb(input int idx);
        logic [3:0] sel;
        sel = 4'(idx % DEF_ENTRIES);
        return DEFAULT_PALETTE[sel];
    endfunction

    // Output bit i (counting down from the MSB) takes source bit
    // 7 - (distance_from_msb mod 8). For widths <= 8 this is plain
    // truncation to the top bits; for wider channels the source pattern
    // repeats, so full-scale stays full-scale (FF -> 3FF for 10 bits).
    // Widths up to 32 bits are supported; the caller slices the result.
    function automatic logic [31:0] adapt_ch8(input logic [7:0] ch8, input int ch_w);
        logic [31:0] res;
        logic [2:0]  src;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < ch_w) begin
                src    = 3'(7 - ((ch_w - 1 - i) % 8));
                res[i] = ch8[src];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// -----------------------------------------------------------------------------
// palette_ram
//   2**ADDR_W x DATA_W memory, one write port and one registered read port.
//   A read and a write to the same address on the same edge return the OLD
//   contents; the new value is visible to reads from the following edge.
//   Contents are not reset: the owner is expected to initialise them.
//
//   Ports:
//     clk_i    : clock
//     we_i     : write enable
//     waddr_i  : write address
//     wdata_i  : write data
//     raddr_i  : read address (sampled every edge)
//     rdata_o  : registered read data, valid one edge after raddr_i
// -----------------------------------------------------------------------------
module palette_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Both statements use non-blocking assignment, so the read sees the
    // array value from before this edge's write (old-data behaviour).
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/color_palette.sv
// -----------------------------------------------------------------------------
// color_palette
//   Maps a pixel colour index to RGB through a writable palette RAM. After
//   reset an init sequencer loads the default rainbow palette (one entry per
//   cycle, 2**IDX_W cycles), then the host may rewrite entries. The read path
//   is two registered stages: RAM read, then brightness scaling and blanking.
//
//   Ports:
//     clk           : system clock
//     rst           : synchronous active-high reset (flushes pipeline,
//                     restarts palette initialisation)
//     wr_en         : palette write strobe
//     wr_idx        : entry to write
//     wr_rgb        : {R,G,B} data to write
//     wr_ready      : high once initialisation is done
//     pix_valid     : pixel index valid this cycle
//     pix_idx       : pixel colour index
//     pix_blank     : force black for this pixel
//     bright        : global brightness, sampled with the pixel
//     out_valid     : pix_valid delayed by two cycles
//     red_channel   : red output   (holds while out_valid is low)
//     green_channel : green output (holds while out_valid is low)
//     blue_channel  : blue output  (holds while out_valid is low)
//
//   Write handshake: a write happens on a clock edge where wr_en && wr_ready
//   are both high; wr_en while wr_ready is low is dropped, not queued. There
//   is no ready/backpressure on the pixel side: one pixel per cycle always.
// -----------------------------------------------------------------------------
module color_palette
    import color_palette_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CH_W  = 8,
    parameter int BR_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [3*CH_W-1:0]  wr_rgb,
    output logic               wr_ready,
    input  logic               pix_valid,
    input  logic [IDX_W-1:0]   pix_idx,
    input  logic               pix_blank,
    input  logic [BR_W-1:0]    bright,
    output logic               out_valid,
    output logic [CH_W-1:0]    red_channel,
    output logic [CH_W-1:0]    green_channel,
    output logic [CH_W-1:0]    blue_channel
);

    localparam int DEPTH  = 2**IDX_W;
    localparam int RGB_W  = 3*CH_W;
    localparam int PROD_W = CH_W + BR_W + 1;

    // ch * (bright + 1) >> BR_W, computed as ch*bright + ch so no operand
    // needs to hold the value 2**BR_W. bright all-ones leaves ch unchanged.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                                 input logic [BR_W-1:0] br);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(ch) * PROD_W'(br) + PROD_W'(ch);
        return prod[BR_W +: CH_W];
    endfunction

    // ---------------------------------------------------------------- FSM
    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    assign wr_ready = (state_q == RUN);

    // ------------------------------------------------- init data & RAM port
    logic [23:0]      def_rgb;
    logic [31:0]      def_r32, def_g32, def_b32;
    logic [RGB_W-1:0] init_rgb;

    always_comb begin
        def_rgb  = default_rgb(int'(init_cnt_q));
        def_r32  = adapt_ch8(def_rgb[23:16], CH_W);
        def_g32  = adapt_ch8(def_rgb[15:8],  CH_W);
        def_b32  = adapt_ch8(def_rgb[7:0],   CH_W);
        init_rgb = {def_r32[CH_W-1:0], def_g32[CH_W-1:0], def_b32[CH_W-1:0]};
    end

    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [RGB_W-1:0] ram_wdata;
    logic [RGB_W-1:0] ram_rdata;

    // The sequencer owns the write port during INIT; host writes are ignored.
    always_comb begin
        ram_we    = wr_en && wr_ready;
        ram_waddr = wr_idx;
        ram_wdata = wr_rgb;
        if (state_q == INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_cnt_q;
            ram_wdata = init_rgb;
        end
    end

    palette_ram #(
        .ADDR_W (IDX_W),
        .DATA_W (RGB_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (pix_idx),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------ stage 1
    // The RAM read register is stage 1's data; pixel side-band travels here.
    // A pixel accepted during INIT would read a half-filled palette, so it
    // is marked black instead.
    logic            s1_valid_q;
    logic            s1_black_q;
    logic [BR_W-1:0] s1_bright_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_black_q  <= 1'b0;
            s1_bright_q <= '0;
        end else begin
            s1_valid_q  <= pix_valid;
            s1_black_q  <= pix_blank || (state_q == INIT);
            s1_bright_q <= bright;
        end
    end

    // ------------------------------------------------------------ stage 2
    logic [CH_W-1:0] red_d, green_d, blue_d;
    logic [CH_W-1:0] red_q, green_q, blue_q;
    logic            out_valid_q;

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (!s1_black_q) begin
            red_d   = scale_ch(ram_rdata[3*CH_W-1 -: CH_W], s1_bright_q);
            green_d = scale_ch(ram_rdata[2*CH_W-1 -: CH_W], s1_bright_q);
            blue_d  = scale_ch(ram_rdata[CH_W-1   -: CH_W], s1_bright_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                red_q   <= red_d;
                green_q <= green_d;
                blue_q  <= blue_d;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign red_channel   = red_q;
    assign green_channel = green_q;
    assign blue_channel  = blue_q;

endmodule

// File: doc/color_palette.md
Name: color_palette

Overview:
- Programmable, parametrised successor to the fixed 16-colour lookup: maps a pixel colour index to RGB through a writable palette RAM.
- Reset loads the default rainbow palette via an init sequencer.
- A 2-stage pipelined read path applies global brightness scaling and blanking.
- Sits between the pixel generator and the VGA/DAC output registers; the host or config logic rewrites entries at runtime.

Parameters:
- IDX_W, 4, colour index width; palette depth = 2**IDX_W entries.
- CH_W, 8, bits per colour channel (R, G, B each).
- BR_W, 4, brightness control width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  palette write strobe; honoured only when wr_ready=1
- wr_idx  in  IDX_W  entry to write
- wr_rgb  in  3*CH_W  {R,G,B} data to write
- wr_ready  out  1  high when init is complete and writes are accepted
- pix_valid  in  1  pixel index valid this cycle
- pix_idx  in  IDX_W  pixel colour index
- pix_blank  in  1  force black for this pixel
- bright  in  BR_W  global brightness, sampled alongside the pixel
- out_valid  out  1  pix_valid delayed by 2 cycles
- red_channel  out  CH_W  red output
- green_channel  out  CH_W  green output
- blue_channel  out  CH_W  blue output

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state<=INIT, init_cnt<=0.
  - Pipeline valids cleared; out_valid=0; all channel outputs 0; wr_ready=0.
  - Reset mid-operation: pipeline flushed and palette re-initialised from entry 0; in-flight pixels are dropped.
- State machine:
  - INIT: each cycle writes default[init_cnt] to entry init_cnt, then increments init_cnt. After entry 2**IDX_W-1 is written, go to RUN. INIT takes exactly 2**IDX_W cycles.
  - RUN: wr_ready=1; stays in RUN until rst.
- Default table (package constant, 16 x 24-bit, index order 0..15): 000000, FF0000, FF8000, FFBF00, FFFF00, BFFF00, 80FF00, 40FF00, 00FF00, 00FF80, 00FFBF, 00FFFF, 0080FF, 0000FF, 4B0082, 8F00FF.
  - Entry i uses default[i mod 16].
  - Each 8-bit channel is adapted to CH_W: if CH_W<=8, take the top CH_W bits; if CH_W>8, left-justify and replicate the MSBs into the low bits.
- Writes: wr_en ignored while in INIT. In RUN, entry wr_idx <= wr_rgb at the clk edge.
- Read path, latency 2 (pixel sampled at edge N -> output valid after edge N+2):
  - Stage 1: registered RAM read of pix_idx; pix_valid, pix_blank and bright registered alongside.
  - Stage 2: ch_out = (ch * (bright + 1)) >> BR_W for each channel, using a CH_W+BR_W+1 bit intermediate; bright = all-ones gives ch unchanged, bright = 0 gives ch >> BR_W. If blank is set, all channels = 0. Outputs registered.
  - Channel outputs update only when the stage-2 valid is 1; otherwise they hold their last value.
- Read-during-write to the same index in the same cycle: the read returns the OLD entry; the new value is visible from the next cycle.
- pix_valid during INIT: the pixel still propagates and out_valid asserts, but the channels output 0 (black).
- Back-to-back pixels: one per cycle, no stalls, no backpressure.

Decomposition:
- Package color_palette_pkg: the 16 x 24-bit default table constant, state enum {INIT, RUN}, and a function that adapts an 8-bit channel to CH_W.
- One sub-module, palette_ram: a 2**IDX_W x 3*CH_W single-write, single-registered-read memory with old-data read-during-write.
- Scaling and blanking stay in the top level.

Test Plan:
- Reset, then hold rst=0 for 16 cycles -> wr_ready=0 for cycles 1-16 and 1 from cycle 17. pix_idx=1, bright=F -> FF/00/00 two cycles later, with out_valid=1.
- After init, pix_idx=14, bright=F -> 4B/00/82. bright=7 -> 25/00/41. bright=0 -> 04/00/08.
- Write idx 3 = 123456, then read idx 3 on the next cycle -> 12/34/56. Same-cycle write of 0xABCDEF with a read of idx 3 -> returns 12/34/56; the following read returns AB/CD/EF.
- Stream indices 0..15 on consecutive cycles with pix_blank=1 on index 5 -> 16 consecutive out_valid cycles, the default colours in order, and index 5 output as 000000.
- Assert rst for one cycle mid-stream -> out_valid drops to 0, wr_ready=0 for 16 cycles, and a previously written entry 3 reads back as the default FFBF00.
- Build with CH_W=4, IDX_W=5: idx 17 -> F/0/0, idx 2 -> F/8/0. Build with CH_W=10: idx 1 -> 3FF/000/000.
